// File: rtl/aes128_package.sv
// Shared types and sizing helpers for the masked AES-128 datapath.
package aes128_package;

  typedef logic [7:0] bv8_t;

  typedef enum logic [1:0] {
    HPC1,
    HPC2,
    HPC3
  } stage_type_t;

  // Fresh random bits per masked inversion: scales with the number of share pairs.
  function automatic int num_inv_random(input int shares, input stage_type_t stageType);
    int pairs;
    int bits;
    pairs = (shares * (shares - 1)) / 2;
    case (stageType)
      HPC1:    bits = 36 * pairs;
      HPC2:    bits = 20 * pairs;
      default: bits = 28 * pairs;
    endcase
    return (bits < 1) ? 1 : bits;
  endfunction

  function automatic int req_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/masked_inv_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the pointer.
module rr_arbiter
  import aes128_package::*;
#(
  parameter int N = 4,
  localparam int IDW = req_id_width(N)
) (
  input  logic           in_clock,
  input  logic           in_reset,
  input  logic           in_enable,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   out_grant,
  output logic [IDW-1:0] out_index,
  output logic           out_issue
);

  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_cand;

  always_comb begin
    out_grant = '0;
    out_index = '0;
    out_issue = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int i = 0; i < N; i++) begin
      w_sum  = {1'b0, r_ptr} + (IDW+1)'(i);
      w_cand = IDW'((w_sum >= (IDW+1)'(N)) ? (w_sum - (IDW+1)'(N)) : w_sum);
      if (in_enable && !out_issue && in_valid[w_cand]) begin
        out_issue         = 1'b1;
        out_index         = w_cand;
        out_grant[w_cand] = 1'b1;
      end
    end
  end

  // The winner moves to the back of the line; the pointer holds when nothing issues.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_ptr <= '0;
    end else if (out_issue) begin
      r_ptr <= (out_index == IDW'(N - 1)) ? '0 : out_index + 1'b1;
    end
  end

endmodule

// File: rtl/masked_inv_sched.sv
// Shares one pipelined masked GF(2^8) inverter between NUM_REQ requesters,
// issuing only when fresh randomness is available and routing results back by tag.
module masked_inv_sched
  import aes128_package::*;
#(
  parameter int          NUM_SHARES  = 2,
  parameter stage_type_t STAGE_TYPE  = HPC1,
  parameter int          NUM_REQ     = 4,
  parameter int          INV_LATENCY = 3,
  localparam int         NUM_RANDOM  = num_inv_random(NUM_SHARES, STAGE_TYPE),
  localparam int         IDW         = req_id_width(NUM_REQ)
) (
  input  logic                                  in_clock,
  input  logic                                  in_reset,
  input  logic                                  in_enable,
  input  logic [NUM_REQ-1:0]                    in_req_valid,
  input  bv8_t [NUM_REQ-1:0][NUM_SHARES-1:0]    in_req_data,
  output logic [NUM_REQ-1:0]                    out_req_ready,
  input  logic [NUM_RANDOM-1:0]                 in_rnd,
  input  logic                                  in_rnd_valid,
  output logic                                  out_rnd_ready,
  output bv8_t [NUM_SHARES-1:0]                 out_inv_a,
  output logic [NUM_RANDOM-1:0]                 out_inv_random,
  input  bv8_t [NUM_SHARES-1:0]                 in_inv_b,
  output logic                                  out_rsp_valid,
  output logic [IDW-1:0]                        out_rsp_id,
  output bv8_t [NUM_SHARES-1:0]                 out_rsp_data,
  output logic                                  out_busy
);

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

  logic               w_arbEnable;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDW-1:0]     w_grantIdx;
  logic               w_issue;
  tag_t               w_stage [INV_LATENCY];

  // Gating with reset keeps every combinational output low while reset is held.
  assign w_arbEnable = in_reset & in_enable & in_rnd_valid;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arbiter (
    .in_clock  (in_clock),
    .in_reset  (in_reset),
    .in_enable (w_arbEnable),
    .in_valid  (in_req_valid),
    .out_grant (w_grant),
    .out_index (w_grantIdx),
    .out_issue (w_issue)
  );

  assign out_req_ready = w_grant;
  assign out_rnd_ready = w_issue;

  // Selection and zero-forcing are done share by share so shares never meet.
  always_comb begin
    out_inv_a      = '0;
    out_inv_random = w_issue ? in_rnd : '0;
    for (int s = 0; s < NUM_SHARES; s++) begin
      out_inv_a[s] = w_issue ? in_req_data[w_grantIdx][s] : 8'h00;
    end
  end

  for (genvar g = 0; g < INV_LATENCY; g++) begin : gen_tag
    tag_t r_tag;
    tag_t w_next;

    if (g == 0) begin : gen_head
      assign w_next = {w_issue, w_grantIdx};
    end else begin : gen_body
      assign w_next = w_stage[g-1];
    end

    always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
        r_tag <= '0;
      end else begin
        r_tag <= w_next;
      end
    end

    assign w_stage[g] = r_tag;
  end

  assign out_rsp_valid = w_stage[INV_LATENCY-1].valid;
  assign out_rsp_id    = w_stage[INV_LATENCY-1].id;

  always_comb begin
    out_busy     = 1'b0;
    out_rsp_data = '0;
    for (int g = 0; g < INV_LATENCY; g++) begin
      out_busy = out_busy | w_stage[g].valid;
    end
    for (int s = 0; s < NUM_SHARES; s++) begin
      out_rsp_data[s] = out_rsp_valid ? in_inv_b[s] : 8'h00;
    end
  end

endmodule

// File: tb/tb_masked_inv_sched.sv
// Directed scoreboard bench for masked_inv_sched with a behavioural 3-cycle masked inverter.
module tb_masked_inv_sched;
  import aes128_package::*;

  localparam int NR = num_inv_random(2, HPC1);

  typedef struct {
    int         id;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [3:0]       reqValid;
  bv8_t [3:0][1:0]  reqData;
  logic [3:0]       reqReady;
  logic [NR-1:0]    rndWord;
  logic             rndValid;
  logic             rndReady;
  bv8_t [1:0]       invA;
  logic [NR-1:0]    invRandom;
  bv8_t [1:0]       invB;
  logic             rspValid;
  logic [1:0]       rspId;
  bv8_t [1:0]       rspData;
  logic             busy;

  bv8_t [1:0] invPipe [3];
  exp_t       expQ [$];
  int         checkCount = 0;
  int         failCount  = 0;
  int         cycleCount = 0;

  masked_inv_sched dut (
    .in_clock       (clock),
    .in_reset       (reset),
    .in_enable      (enable),
    .in_req_valid   (reqValid),
    .in_req_data    (reqData),
    .out_req_ready  (reqReady),
    .in_rnd         (rndWord),
    .in_rnd_valid   (rndValid),
    .out_rnd_ready  (rndReady),
    .out_inv_a      (invA),
    .out_inv_random (invRandom),
    .in_inv_b       (invB),
    .out_rsp_valid  (rspValid),
    .out_rsp_id     (rspId),
    .out_rsp_data   (rspData),
    .out_busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCount++;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] gfInv(input logic [7:0] x);
    for (int y = 1; y < 256; y++) begin
      if (gfMul(x, 8'(y)) == 8'h01) return 8'(y);
    end
    return 8'h00;
  endfunction

  // Masked inverter stand-in: re-shares the inverse with a mask taken from the randomness.
  always @(posedge clock) begin
    invPipe[0][0] <= gfInv(invA[0] ^ invA[1]) ^ invRandom[7:0];
    invPipe[0][1] <= invRandom[7:0];
    invPipe[1]    <= invPipe[0];
    invPipe[2]    <= invPipe[1];
  end
  assign invB = invPipe[2];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  // Response monitor: pops the scoreboard whenever the scheduler presents a result.
  always @(negedge clock) begin
    exp_t e;
    if (rspValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected_rsp_id", 64'(rspId), 64'hFFFF);
      end else begin
        e = expQ.pop_front();
        checkVal("rsp_id", 64'(rspId), 64'(e.id));
        checkVal("rsp_value", 64'(rspData[0] ^ rspData[1]), 64'(e.val));
        checkVal("rsp_latency", 64'(cycleCount - e.cyc), 64'd3);
      end
    end else begin
      checkVal("rsp_data_idle", 64'(rspData), 64'd0);
    end
  end

  task automatic checkOutput(input int expGrant, input int expInv);
    logic [3:0] expReady;
    exp_t       e;
    expReady = (expGrant < 0) ? 4'b0000 : 4'(1 << expGrant);
    checkVal("req_ready", 64'(reqReady), 64'(expReady));
    checkVal("rnd_ready", 64'(rndReady), 64'(expGrant >= 0));
    if (expGrant >= 0) begin
      checkVal("inv_a", 64'(invA), 64'(reqData[expGrant]));
      checkVal("inv_random", 64'(invRandom), 64'(rndWord));
      e.id  = expGrant;
      e.val = (expInv < 0) ? gfInv(reqData[expGrant][0] ^ reqData[expGrant][1]) : 8'(expInv);
      e.cyc = cycleCount;
      expQ.push_back(e);
    end else begin
      checkVal("idle_inv_a", 64'(invA), 64'd0);
      checkVal("idle_inv_random", 64'(invRandom), 64'd0);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic rndV, input logic en,
                               input int expGrant, input int expInv);
    @(posedge clock);
    #1;
    reqValid = valid;
    rndValid = rndV;
    enable   = en;
    rndWord  = NR'({$urandom(), $urandom()});
    #2;
    checkOutput(expGrant, expInv);
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b0;
    reqValid = 4'b0000;
    rndValid = 1'b0;
    rndWord  = '0;
    reqData[0][0] = 8'h3C; reqData[0][1] = 8'h55;
    reqData[1][0] = 8'hA7; reqData[1][1] = 8'h01;
    reqData[2][0] = 8'h11; reqData[2][1] = 8'h42;
    reqData[3][0] = 8'hFF; reqData[3][1] = 8'h00;

    // Held in reset with everything requesting: nothing may be granted.
    applyStimulus(4'b1111, 1'b1, 1'b1, -1, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, -1, -1);
    checkVal("reset_busy", 64'(busy), 64'd0);
    checkVal("reset_rsp_valid", 64'(rspValid), 64'd0);
    @(posedge clock);
    #1;
    reqValid = 4'b0000;
    reset    = 1'b1;

    // Single request from requester 2: 0x11 ^ 0x42 = 0x53, inverse 0xCA.
    applyStimulus(4'b0100, 1'b1, 1'b1, 2, 'hCA);
    for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 1'b1, 1'b1, -1, -1);

    // Everyone valid: rotation starts after requester 2.
    applyStimulus(4'b1111, 1'b1, 1'b1, 3, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 0, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 2, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 3, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 0, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 1, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 2, -1);

    // Randomness gap freezes the pointer.
    applyStimulus(4'b0011, 1'b1, 1'b1, 0, -1);
    applyStimulus(4'b0011, 1'b0, 1'b1, -1, -1);
    applyStimulus(4'b0011, 1'b1, 1'b1, 1, -1);
    applyStimulus(4'b0011, 1'b1, 1'b1, 0, -1);
    for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 1'b1, 1'b1, -1, -1);

    // Enable dropped after two issues; busy stays up while the tags drain.
    applyStimulus(4'b1111, 1'b1, 1'b1, 1, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, 2, -1);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, -1, -1);
      checkVal("busy_drain", 64'(busy), 64'(k < 3));
    end

    // A lone requester may issue every cycle.
    applyStimulus(4'b0001, 1'b1, 1'b1, 0, -1);
    applyStimulus(4'b0001, 1'b1, 1'b1, 0, -1);
    applyStimulus(4'b0001, 1'b1, 1'b1, 0, -1);
    for (int k = 0; k < 4; k++) applyStimulus(4'b0000, 1'b1, 1'b1, -1, -1);

    // Reset with three operations in flight drops them and clears the pointer.
    applyStimulus(4'b0111, 1'b1, 1'b1, 1, -1);
    applyStimulus(4'b0111, 1'b1, 1'b1, 2, -1);
    applyStimulus(4'b0111, 1'b1, 1'b1, 0, -1);
    @(posedge clock);
    #1;
    reset    = 1'b0;
    reqValid = 4'b0000;
    #1;
    checkVal("midreset_busy", 64'(busy), 64'd0);
    checkVal("midreset_rsp_valid", 64'(rspValid), 64'd0);
    expQ.delete();
    applyStimulus(4'b1111, 1'b1, 1'b1, -1, -1);
    applyStimulus(4'b1111, 1'b1, 1'b1, -1, -1);
    @(posedge clock);
    #1;
    reqValid = 4'b0000;
    reset    = 1'b1;
    applyStimulus(4'b1111, 1'b1, 1'b1, 0, -1);
    for (int k = 0; k < 5; k++) applyStimulus(4'b0000, 1'b1, 1'b1, -1, -1);

    checkVal("queue_empty", 64'(expQ.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
